// File: rtl/nano6502_pkg.sv
// Shared nano6502 definitions: DMA register map, CTRL/STATUS bit positions,
// DMA controller state encoding and the io bank the decoder uses for the DMA.
package nano6502_pkg;
  localparam logic [7:0] IO_BANK_DMA = 8'h07;

  localparam logic [2:0] DMA_REG_SRC_L  = 3'd0;
  localparam logic [2:0] DMA_REG_SRC_H  = 3'd1;
  localparam logic [2:0] DMA_REG_DST_L  = 3'd2;
  localparam logic [2:0] DMA_REG_DST_H  = 3'd3;
  localparam logic [2:0] DMA_REG_LEN_L  = 3'd4;
  localparam logic [2:0] DMA_REG_LEN_H  = 3'd5;
  localparam logic [2:0] DMA_REG_CTRL   = 3'd6;
  localparam logic [2:0] DMA_REG_STATUS = 3'd7;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FILL   = 2;
  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;

  typedef enum logic [2:0] {IDLE, REQ, READ, CAPT, WRITE, DONE} dma_state_t;
endpackage

// File: rtl/dma_ctrl_if.sv
// DMA controller signal bundle: CPU register window plus the DMA bus side.
// slave = the DMA controller, master = the system (CPU/decoder/memory) side.
interface dma_ctrl_if;
  logic        cs_i;
  logic        R_W_n;
  logic [2:0]  addr_i;
  logic [7:0]  data_i;
  logic [7:0]  data_o;
  logic        rdy_o;
  logic        bus_req_o;
  logic [15:0] dma_addr_o;
  logic        dma_r_w_n_o;
  logic [7:0]  dma_data_o;
  logic [7:0]  dma_data_i;
  logic        irq_o;

  modport slave (
    input  cs_i, R_W_n, addr_i, data_i, dma_data_i,
    output data_o, rdy_o, bus_req_o, dma_addr_o, dma_r_w_n_o, dma_data_o, irq_o
  );
  modport master (
    output cs_i, R_W_n, addr_i, data_i, dma_data_i,
    input  data_o, rdy_o, bus_req_o, dma_addr_o, dma_r_w_n_o, dma_data_o, irq_o
  );
endinterface

// File: rtl/dma_ctrl_regs.sv
// dma_regs: programmed register file, read mux, START pulse and DONE/IRQ flag.
// CTRL.FILL is only writable when DMA_FILL_EN is defined.
module dma_regs
  import nano6502_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr,
  input  logic [2:0]  addr,
  input  logic [7:0]  wdata,
  input  logic        busy,
  input  logic        done_set,
  output logic [7:0]  rdata,
  output logic [15:0] src,
  output logic [15:0] dst,
  output logic [15:0] len,
  output logic        irq_en,
  output logic        fill,
  output logic        go,
  output logic        irq
);
`ifdef DMA_FILL_EN
  localparam bit FILL_OK = 1'b1;
`else
  localparam bit FILL_OK = 1'b0;
`endif

  logic [5:0][7:0] cfg;
  logic            done;

  assign src = {cfg[1], cfg[0]};
  assign dst = {cfg[3], cfg[2]};
  assign len = {cfg[5], cfg[4]};
  assign go  = wr && addr == DMA_REG_CTRL && wdata[CTRL_START] && !busy;
  assign irq = done & irq_en;

  // Register writes; address/length/mode frozen while a transfer runs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg    <= '0;
      irq_en <= 1'b0;
      fill   <= 1'b0;
      done   <= 1'b0;
    end else begin
      if (wr && !busy && addr <= DMA_REG_LEN_H) cfg[addr] <= wdata;
      if (wr && addr == DMA_REG_CTRL) begin
        irq_en <= wdata[CTRL_IRQ_EN];
        if (!busy) fill <= wdata[CTRL_FILL] & FILL_OK;
      end
      // completion set has priority over a software clear
      if (done_set) done <= 1'b1;
      else if (wr && addr == DMA_REG_STATUS && wdata[STAT_DONE]) done <= 1'b0;
    end
  end

  // Read mux returns programmed values, never the working counters
  always_comb begin
    rdata = 8'h00;
    case (addr)
      DMA_REG_CTRL:   rdata = {5'b0, fill, irq_en, 1'b0};
      DMA_REG_STATUS: rdata = {6'b0, done, busy};
      default:        rdata = cfg[addr];
    endcase
  end
endmodule

// File: rtl/dma_ctrl.sv
// dma_ctrl: nano6502 memory-to-memory DMA. Stalls the CPU via RDY, owns the
// bus for READ/CAPT/WRITE per byte, then flags DONE. Optional block fill is
// enabled by defining DMA_FILL_EN.
module dma_ctrl
  import nano6502_pkg::*;
#(
  parameter int HALT_CYCLES = 1
) (
  input logic       clk_i,
  input logic       rst_n_i,
  dma_ctrl_if.slave bus
);
  dma_state_t  state;
  logic [15:0] src_q, dst_q, cnt_q;
  logic [7:0]  byte_q;
  logic [2:0]  hcnt;
  logic        fill_q;
  logic        rdy, bus_req, r_w_n;
  logic [15:0] addr;
  logic [7:0]  dout;

  logic [15:0] src, dst, len;
  logic [7:0]  rdata;
  logic        irq_en, fill, go, irq;

  dma_regs u_regs (
    .clk      (clk_i),
    .rst_n    (rst_n_i),
    .wr       (bus.cs_i & ~bus.R_W_n),
    .addr     (bus.addr_i),
    .wdata    (bus.data_i),
    .busy     (state != IDLE),
    .done_set (state == DONE),
    .rdata    (rdata),
    .src      (src),
    .dst      (dst),
    .len      (len),
    .irq_en   (irq_en),
    .fill     (fill),
    .go       (go),
    .irq      (irq)
  );

  assign bus.data_o      = bus.cs_i ? rdata : 8'h00;
  assign bus.rdy_o       = rdy;
  assign bus.bus_req_o   = bus_req;
  assign bus.dma_addr_o  = addr;
  assign bus.dma_r_w_n_o = r_w_n;
  assign bus.dma_data_o  = dout;
  assign bus.irq_o       = irq;

  // Transfer FSM; bus outputs are registered alongside each state change
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      byte_q  <= '0;
      hcnt    <= '0;
      fill_q  <= 1'b0;
      rdy     <= 1'b1;
      bus_req <= 1'b0;
      r_w_n   <= 1'b1;
      addr    <= '0;
      dout    <= '0;
    end else begin
      case (state)
        IDLE: if (go) begin
          src_q  <= src;
          dst_q  <= dst;
          cnt_q  <= len;
          fill_q <= fill;
          byte_q <= src[7:0];
          hcnt   <= 3'(HALT_CYCLES - 1);
          rdy    <= 1'b0;
          state  <= REQ;
        end
        REQ: begin
          if (hcnt != 3'd0) hcnt <= hcnt - 3'd1;
          else if (cnt_q == 16'd0) state <= DONE;
          else if (fill_q) begin
            state   <= WRITE;
            bus_req <= 1'b1;
            addr    <= dst_q;
            r_w_n   <= 1'b0;
            dout    <= byte_q;
          end else begin
            state   <= READ;
            bus_req <= 1'b1;
            addr    <= src_q;
            r_w_n   <= 1'b1;
          end
        end
        READ: state <= CAPT;
        CAPT: begin
          // memory data is valid this cycle; forward it straight to the write
          byte_q <= bus.dma_data_i;
          dout   <= bus.dma_data_i;
          addr   <= dst_q;
          r_w_n  <= 1'b0;
          state  <= WRITE;
        end
        WRITE: begin
          if (!fill_q) src_q <= src_q + 16'd1;
          dst_q <= dst_q + 16'd1;
          cnt_q <= cnt_q - 16'd1;
          if (cnt_q != 16'd1) begin
            if (fill_q) addr <= dst_q + 16'd1;
            else begin
              state <= READ;
              addr  <= src_q + 16'd1;
              r_w_n <= 1'b1;
              dout  <= 8'h00;
            end
          end else begin
            state   <= DONE;
            bus_req <= 1'b0;
            addr    <= '0;
            r_w_n   <= 1'b1;
            dout    <= 8'h00;
          end
        end
        DONE: begin
          rdy   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_ctrl.sv
// Bench for dma_ctrl: register readback table, then copy / zero length /
// wrap / irq / busy-protection / reset-abort sequences (fill when DMA_FILL_EN).
// Bus writes and read addresses are scoreboarded against queued expectations.
module tb_dma_ctrl;
  import nano6502_pkg::*;
  localparam int HALT = 1;
`ifdef DMA_FILL_EN
  localparam logic [7:0] FILL_RB = 8'h04;
`else
  localparam logic [7:0] FILL_RB = 8'h00;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dma_ctrl_if bus ();
  dma_ctrl #(.HALT_CYCLES(HALT)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

  // memory model: synchronous read (data one cycle after address), tb pokes
  logic [7:0]  mem [0:65535];
  logic        pk_we = 1'b0;
  logic [15:0] pk_a = '0;
  logic [7:0]  pk_d = '0;
  always @(posedge clk) begin
    if (pk_we) mem[pk_a] <= pk_d;
    else if (bus.bus_req_o && !bus.dma_r_w_n_o) mem[bus.dma_addr_o] <= bus.dma_data_o;
    bus.dma_data_i <= mem[bus.dma_addr_o];
  end

  int vec = 0;
  int err = 0;
  logic [23:0] exp_wr [$];
  logic [15:0] exp_rd [$];

  typedef struct { logic [2:0] a; logic [7:0] wd; logic [7:0] exp; } vec_t;
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // all bus tasks are entered in the low half of the clock
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.cs_i = 1'b1; bus.R_W_n = 1'b0; bus.addr_i = a; bus.data_i = d;
    @(negedge clk);
    bus.cs_i = 1'b0; bus.R_W_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    bus.cs_i = 1'b1; bus.R_W_n = 1'b1; bus.addr_i = a;
    #1 d = bus.data_o;
    bus.cs_i = 1'b0;
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    pk_we = 1'b1; pk_a = a; pk_d = d;
    @(negedge clk);
    pk_we = 1'b0;
  endtask

  task automatic prog(input logic [15:0] s, input logic [15:0] t, input logic [15:0] n);
    wr(DMA_REG_SRC_L, s[7:0]); wr(DMA_REG_SRC_H, s[15:8]);
    wr(DMA_REG_DST_L, t[7:0]); wr(DMA_REG_DST_H, t[15:8]);
    wr(DMA_REG_LEN_L, n[7:0]); wr(DMA_REG_LEN_H, n[15:8]);
  endtask

  // follow a transfer until rdy returns; score writes (and optionally reads)
  task automatic run_xfer(input bit chk_rd, output int low, output bit req);
    bit prev_rd = 1'b0;
    bit fin = 1'b0;
    low = 0; req = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (bus.rdy_o) begin fin = 1'b1; break; end
      low++;
      if (bus.bus_req_o) req = 1'b1;
      if (bus.bus_req_o && !bus.dma_r_w_n_o) begin
        if (exp_wr.size() == 0) chk("extra_write", 32'(bus.dma_addr_o), 32'hFFFFFFFF);
        else chk("write", {8'h0, bus.dma_addr_o, bus.dma_data_o}, 32'(exp_wr.pop_front()));
      end
      if (chk_rd && bus.bus_req_o && bus.dma_r_w_n_o && !prev_rd) begin
        if (exp_rd.size() == 0) chk("extra_read", 32'(bus.dma_addr_o), 32'hFFFFFFFF);
        else chk("read_addr", 32'(bus.dma_addr_o), 32'(exp_rd.pop_front()));
      end
      prev_rd = bus.bus_req_o && bus.dma_r_w_n_o;
      @(negedge clk);
    end
    if (!fin) chk("timeout", 32'd1, 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdy"},   32'(bus.rdy_o),       32'd1);
    chk({tag, "_req"},   32'(bus.bus_req_o),   32'd0);
    chk({tag, "_addr"},  32'(bus.dma_addr_o),  32'd0);
    chk({tag, "_rwn"},   32'(bus.dma_r_w_n_o), 32'd1);
    chk({tag, "_dout"},  32'(bus.dma_data_o),  32'd0);
    chk({tag, "_irq"},   32'(bus.irq_o),       32'd0);
  endtask

  initial begin
    logic [7:0] d;
    int low;
    bit req;
    bus.cs_i = 1'b0; bus.R_W_n = 1'b1; bus.addr_i = '0; bus.data_i = '0;
    tbl[0] = '{DMA_REG_SRC_L, 8'h00, 8'h00};
    tbl[1] = '{DMA_REG_SRC_H, 8'h02, 8'h02};
    tbl[2] = '{DMA_REG_DST_L, 8'h00, 8'h00};
    tbl[3] = '{DMA_REG_DST_H, 8'h03, 8'h03};
    tbl[4] = '{DMA_REG_LEN_L, 8'h04, 8'h04};
    tbl[5] = '{DMA_REG_LEN_H, 8'h00, 8'h00};
    tbl[6] = '{DMA_REG_CTRL,  8'h02, 8'h02};
    tbl[7] = '{DMA_REG_CTRL,  8'h04, FILL_RB};
    tbl[8] = '{DMA_REG_CTRL,  8'h00, 8'h00};
    tbl[9] = '{DMA_REG_STATUS, 8'h02, 8'h00};

    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    #1 chk("reset_data_o", 32'(bus.data_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    rd(DMA_REG_STATUS, d); chk("reset_status", 32'(d), 32'd0);

    // register table: write then read back (programs the first copy)
    for (int i = 0; i < 10; i++) begin
      wr(tbl[i].a, tbl[i].wd);
      rd(tbl[i].a, d);
      chk($sformatf("reg_rb%0d", i), 32'(d), 32'(tbl[i].exp));
    end

    // copy 4 bytes 0x0200 -> 0x0300
    poke(16'h0200, 8'h11); poke(16'h0201, 8'h22); poke(16'h0202, 8'h33); poke(16'h0203, 8'h44);
    exp_wr.push_back({16'h0300, 8'h11}); exp_wr.push_back({16'h0301, 8'h22});
    exp_wr.push_back({16'h0302, 8'h33}); exp_wr.push_back({16'h0303, 8'h44});
    wr(DMA_REG_CTRL, 8'h01);
    run_xfer(1'b0, low, req);
    chk("copy_rdy_low", 32'(low), 32'(HALT + 3 * 4 + 1));
    chk("copy_q_empty", 32'(exp_wr.size()), 32'd0);
    chk("copy_mem3", 32'(mem[16'h0303]), 32'h44);
    rd(DMA_REG_STATUS, d); chk("copy_status", 32'(d), 32'h02);
    rd(DMA_REG_SRC_L, d);  chk("copy_src_rb", 32'(d), 32'h00);
    rd(DMA_REG_LEN_L, d);  chk("copy_len_rb", 32'(d), 32'h04);
    wr(DMA_REG_STATUS, 8'h02);
    rd(DMA_REG_STATUS, d); chk("done_clear", 32'(d), 32'h00);

    // zero length: no bus ownership
    wr(DMA_REG_LEN_L, 8'h00);
    wr(DMA_REG_CTRL, 8'h01);
    run_xfer(1'b0, low, req);
    chk("len0_rdy_low", 32'(low), 32'(HALT + 1));
    chk("len0_no_req", 32'(req), 32'd0);
    rd(DMA_REG_STATUS, d); chk("len0_status", 32'(d), 32'h02);
    wr(DMA_REG_STATUS, 8'h02);

    // source address wrap
    poke(16'hFFFE, 8'hA1); poke(16'hFFFF, 8'hB2); poke(16'h0000, 8'hC3);
    prog(16'hFFFE, 16'h1000, 16'd3);
    exp_rd.push_back(16'hFFFE); exp_rd.push_back(16'hFFFF); exp_rd.push_back(16'h0000);
    exp_wr.push_back({16'h1000, 8'hA1}); exp_wr.push_back({16'h1001, 8'hB2});
    exp_wr.push_back({16'h1002, 8'hC3});
    wr(DMA_REG_CTRL, 8'h01);
    run_xfer(1'b1, low, req);
    chk("wrap_rd_empty", 32'(exp_rd.size()), 32'd0);
    chk("wrap_wr_empty", 32'(exp_wr.size()), 32'd0);
    wr(DMA_REG_STATUS, 8'h02);

    // irq on a 1-byte copy, dropped by clearing DONE
    prog(16'h0200, 16'h0310, 16'd1);
    exp_wr.push_back({16'h0310, 8'h11});
    wr(DMA_REG_CTRL, 8'h02);
    chk("irq_idle_low", 32'(bus.irq_o), 32'd0);
    wr(DMA_REG_CTRL, 8'h03);
    run_xfer(1'b0, low, req);
    chk("irq_rise", 32'(bus.irq_o), 32'd1);
    wr(DMA_REG_STATUS, 8'h02);
    chk("irq_clear", 32'(bus.irq_o), 32'd0);

    // busy protection: DST write and re-START ignored mid-copy
    wr(DMA_REG_CTRL, 8'h00);
    prog(16'h0200, 16'h0320, 16'd4);
    exp_wr.push_back({16'h0320, 8'h11}); exp_wr.push_back({16'h0321, 8'h22});
    exp_wr.push_back({16'h0322, 8'h33}); exp_wr.push_back({16'h0323, 8'h44});
    wr(DMA_REG_CTRL, 8'h01);
    wr(DMA_REG_DST_H, 8'h50);
    wr(DMA_REG_DST_L, 8'h00);
    wr(DMA_REG_CTRL, 8'h01);
    run_xfer(1'b0, low, req);
    chk("busy_rdy_low", 32'(low), 32'(HALT + 3 * 4 + 1 - 3));
    chk("busy_q_empty", 32'(exp_wr.size()), 32'd0);
    rd(DMA_REG_DST_H, d); chk("busy_dst_rb", 32'(d), 32'h03);
    @(negedge clk);
    chk("busy_no_restart", 32'(bus.rdy_o), 32'd1);
    wr(DMA_REG_STATUS, 8'h02);

`ifdef DMA_FILL_EN
    prog(16'h00A5, 16'h0400, 16'd3);
    exp_wr.push_back({16'h0400, 8'hA5}); exp_wr.push_back({16'h0401, 8'hA5});
    exp_wr.push_back({16'h0402, 8'hA5});
    wr(DMA_REG_CTRL, 8'h05);
    run_xfer(1'b0, low, req);
    chk("fill_rdy_low", 32'(low), 32'(HALT + 3 + 1));
    chk("fill_q_empty", 32'(exp_wr.size()), 32'd0);
    chk("fill_mem2", 32'(mem[16'h0402]), 32'hA5);
    wr(DMA_REG_STATUS, 8'h02);
    prog(16'h005A, 16'h0500, 16'd16);
`else
    prog(16'h0200, 16'h0500, 16'd16);
`endif

    // reset mid-transfer aborts at once
    wr(DMA_REG_CTRL, 8'h07);
    repeat (4) @(negedge clk);
    chk("abort_busy", 32'(bus.bus_req_o), 32'd1);
    rst_n = 1'b0;
    #1 chk_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    rd(DMA_REG_STATUS, d); chk("abort_status", 32'(d), 32'h00);
    rd(DMA_REG_DST_H, d);  chk("abort_dst_rb", 32'(d), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
